// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the mem-stage data-RAM port.
// One load/store per req/ack handshake, fixed access latency, byte/half/word lanes.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  busy_o
);
  // state  | meaning
  // S_IDLE | waiting for req_i; request captured on the sampling edge
  // S_WAIT | access latency, cnt counts down to 0
  // S_RESP | ack_o high for one cycle; stores commit on the edge leaving it

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic                    we_q;
  logic [1:0]              size_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    src_we;
  logic [1:0]              src_size;
  logic [ADDR_WIDTH-1:0]   src_addr;
  logic [ADDR_WIDTH-3:0]   src_idx;
  logic                    src_err;
  logic [DATA_WIDTH-1:0]   src_word;
  logic [DATA_WIDTH-1:0]   rd_val;
  logic [NB-1:0]           be;
  logic [DATA_WIDTH-1:0]   wlane;
  logic                    mem_we;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (req_i) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nxt = S_RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == S_IDLE && req_i) begin
      we_q    <= we_i;
      size_q  <= size_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end
  end

  // With zero wait cycles RESP is entered on the sampling edge itself, so the
  // response is computed from the live inputs (identical to what gets captured).
  always_comb begin
    if (state == S_IDLE) begin
      src_we   = we_i;
      src_size = size_i;
      src_addr = addr_i;
    end else begin
      src_we   = we_q;
      src_size = size_q;
      src_addr = addr_q;
    end
  end

  assign src_idx  = src_addr[ADDR_WIDTH-1:2];
  assign src_err  = (src_size == 2'b11)
                 || (src_size == 2'b01 && src_addr[0])
                 || (src_size == 2'b10 && src_addr[1:0] != 2'b00)
                 || ({2'b00, src_idx} >= ADDR_WIDTH'(DEPTH));
  assign src_word = mem[src_idx[IW-1:0]];

  always_comb begin
    case (src_size)
      2'b00:   rd_val = {{(DATA_WIDTH-8){1'b0}},  src_word[{src_addr[1:0], 3'b000} +: 8]};
      2'b01:   rd_val = {{(DATA_WIDTH-16){1'b0}}, src_word[{src_addr[1], 4'b0000} +: 16]};
      default: rd_val = src_word;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else if (state_nxt == S_RESP) begin
      ack_o   <= 1'b1;
      err_o   <= src_err;
      rdata_o <= (src_err || src_we) ? '0 : rd_val;
    end else begin
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end
  end

  always_comb begin
    be    = '1;
    wlane = wdata_q;
    case (size_q)
      2'b00: begin
        be    = NB'(1) << addr_q[1:0];
        wlane = {NB{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = NB'(3) << {addr_q[1], 1'b0};
        wlane = {(NB/2){wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  // err_o holds the registered error decision during RESP, gating the commit.
  assign mem_we = (state == S_RESP) && we_q && !err_o;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[addr_q[IW+1:2]][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  assign busy_o = req_i & ~ack_o;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (zero and two wait cycles) checked
// against a byte-addressed reference memory.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam logic [31:0] BASE = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req [2];
  logic        we [2];
  logic [1:0]  size [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ack [2];
  logic        err [2];
  logic        busy [2];

  logic [7:0]  ref_mem [2][4*DEPTH];
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .size_i(size[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]), .ack_o(ack[0]),
    .err_o(err[0]), .busy_o(busy[0]));

  dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .size_i(size[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]), .ack_o(ack[1]),
    .err_o(err[1]), .busy_o(busy[1]));

  function automatic logic model_err(logic [1:0] sz, logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
    return (a / 4) >= DEPTH;
  endfunction

  function automatic logic [31:0] model_load(int s, logic [1:0] sz, logic [31:0] a);
    logic [31:0] v = 0;
    for (int i = 0; i < (1 << sz); i++) v = v | (32'(ref_mem[s][a + i]) << (8 * i));
    return v;
  endfunction

  function automatic void model_store(int s, logic [1:0] sz, logic [31:0] a, logic [31:0] v);
    for (int i = 0; i < (1 << sz); i++) ref_mem[s][a + i] = v[8*i +: 8];
  endfunction

  // Drives one request, reports latency (negedges after the sampling edge, -1 on
  // timeout), response fields, busy_o violations and leftover response activity.
  task automatic run_req(input int s, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] v, input logic scramble,
                         output int lat, output logic [31:0] rd, output logic er,
                         output int busy_bad, output int tail_bad);
    lat = -1; rd = 'x; er = 'x; busy_bad = 0; tail_bad = 0;
    @(negedge clk);
    req[s] = 1'b1; we[s] = w; size[s] = sz; addr[s] = a; wdata[s] = v;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ack[s] === 1'b1) begin
        lat = k; rd = rdata[s]; er = err[s];
        if (busy[s] !== 1'b0) busy_bad++;
        req[s] = 1'b0;
        break;
      end
      if (busy[s] !== 1'b1) busy_bad++;
      if (k == 1 && scramble) begin
        we[s] = ~w; size[s] = 2'($urandom); addr[s] = $urandom; wdata[s] = $urandom;
      end
    end
    req[s] = 1'b0;
    @(negedge clk);
    if (ack[s] !== 1'b0 || err[s] !== 1'b0 || rdata[s] !== 32'h0) tail_bad++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_cmp++; if (ack[s] !== 1'b0) begin n_fail++; $display("FAIL reset_ack[%0d]: got %b want 0", s, ack[s]); end
      n_cmp++; if (err[s] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b want 0", s, err[s]); end
      n_cmp++; if (rdata[s] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h want 0", s, rdata[s]); end
      n_cmp++; if (busy[s] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", s, busy[s]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_word();
    int lat, bb, tb; logic [31:0] rd; logic er;
    run_req(1, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, lat, rd, er, bb, tb);
    n_cmp++; if (lat !== 3 || er !== 1'b0) begin n_fail++; $display("FAIL t1_store: lat %0d err %b want lat 3 err 0", lat, er); end
    run_req(1, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, lat, rd, er, bb, tb);
    n_cmp++; if (lat !== 3 || er !== 1'b0) begin n_fail++; $display("FAIL t1_load: lat %0d err %b want lat 3 err 0", lat, er); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t1_rdata: got %h want deadbeef", rd); end
    n_cmp++; if (bb !== 0 || tb !== 0) begin n_fail++; $display("FAIL t1_busy_tail: busy_bad %0d tail_bad %0d want 0 0", bb, tb); end
  endtask

  task automatic test_lanes();
    int lat, bb, tb; logic [31:0] rd; logic er;
    run_req(1, 1'b1, 2'd2, 32'h20, 32'h0, 1'b0, lat, rd, er, bb, tb);
    run_req(1, 1'b1, 2'd0, 32'h23, 32'hFFFFFFAB, 1'b0, lat, rd, er, bb, tb);
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL t2_byte_store_err: got %b want 0", er); end
    run_req(1, 1'b1, 2'd1, 32'h20, 32'hFFFF1234, 1'b0, lat, rd, er, bb, tb);
    run_req(1, 1'b0, 2'd2, 32'h20, 32'h0, 1'b0, lat, rd, er, bb, tb);
    n_cmp++; if (rd !== 32'hAB001234) begin n_fail++; $display("FAIL t2_word_load: got %h want ab001234", rd); end
    run_req(1, 1'b0, 2'd0, 32'h23, 32'h0, 1'b0, lat, rd, er, bb, tb);
    n_cmp++; if (rd !== 32'h000000AB) begin n_fail++; $display("FAIL t2_byte_load: got %h want 000000ab", rd); end
    run_req(1, 1'b0, 2'd1, 32'h22, 32'h0, 1'b0, lat, rd, er, bb, tb);
    n_cmp++; if (rd !== 32'h0000AB00) begin n_fail++; $display("FAIL t2_half_load: got %h want 0000ab00", rd); end
  endtask

  task automatic test_errors();
    int lat, bb, tb; logic [31:0] rd; logic er;
    run_req(1, 1'b1, 2'd2, 32'h22, 32'h99999999, 1'b0, lat, rd, er, bb, tb);
    n_cmp++; if (lat !== 3 || er !== 1'b1) begin n_fail++; $display("FAIL t3_misaligned_store: lat %0d err %b want 3 1", lat, er); end
    run_req(1, 1'b0, 2'd2, 32'h20, 32'h0, 1'b0, lat, rd, er, bb, tb);
    n_cmp++; if (rd !== 32'hAB001234 || er !== 1'b0) begin n_fail++; $display("FAIL t3_unchanged: got %h err %b want ab001234 0", rd, er); end
    run_req(1, 1'b0, 2'd2, 32'(4*DEPTH), 32'h0, 1'b0, lat, rd, er, bb, tb);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL t3_out_of_range: err %b rdata %h want 1 0", er, rd); end
    run_req(1, 1'b0, 2'd2, 32'(4*DEPTH - 4), 32'h0, 1'b0, lat, rd, er, bb, tb);
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL t3_last_word: err %b want 0", er); end
    run_req(1, 1'b0, 2'd1, 32'h21, 32'h0, 1'b0, lat, rd, er, bb, tb);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL t3_half_odd: err %b rdata %h want 1 0", er, rd); end
    run_req(1, 1'b0, 2'd3, 32'h20, 32'h0, 1'b0, lat, rd, er, bb, tb);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL t3_size3: err %b rdata %h want 1 0", er, rd); end
  endtask

  task automatic test_zero_latency();
    int lat, bb, tb; logic [31:0] rd; logic er;
    logic [31:0] vals [3];
    logic exp_ack, exp_busy;
    for (int i = 0; i < 3; i++) begin
      vals[i] = $urandom;
      run_req(0, 1'b1, 2'd2, 32'h80 + 32'(4*i), vals[i], 1'b0, lat, rd, er, bb, tb);
      n_cmp++; if (lat !== 1 || er !== 1'b0) begin n_fail++; $display("FAIL t4_preload: lat %0d err %b want 1 0", lat, er); end
    end
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; size[0] = 2'd2; addr[0] = 32'h80;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_ack  = (k % 2 == 0);
      exp_busy = (k % 2 == 1) && (k < 5);
      n_cmp++; if (ack[0] !== exp_ack) begin n_fail++; $display("FAIL t4_ack@%0d: got %b want %b", k, ack[0], exp_ack); end
      n_cmp++; if (busy[0] !== exp_busy) begin n_fail++; $display("FAIL t4_busy@%0d: got %b want %b", k, busy[0], exp_busy); end
      if (exp_ack) begin
        n_cmp++; if (rdata[0] !== vals[k/2]) begin n_fail++; $display("FAIL t4_rdata@%0d: got %h want %h", k, rdata[0], vals[k/2]); end
        if (k / 2 < 2) addr[0] = 32'h80 + 32'(4 * (k/2 + 1));
        else           req[0] = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, bb, tb, seen; logic [31:0] rd; logic er;
    run_req(1, 1'b1, 2'd2, 32'h30, 32'h11223344, 1'b0, lat, rd, er, bb, tb);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; size[1] = 2'd2; addr[1] = 32'h30; wdata[1] = 32'h55;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; req[1] = 1'b0;
    #1;
    n_cmp++; if (ack[1] !== 1'b0 || err[1] !== 1'b0) begin n_fail++; $display("FAIL t5_in_reset: ack %b err %b want 0 0", ack[1], err[1]); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack[1] !== 1'b0) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL t5_no_ack: got %0d ack cycles want 0", seen); end
    run_req(1, 1'b0, 2'd2, 32'h30, 32'h0, 1'b0, lat, rd, er, bb, tb);
    n_cmp++; if (rd !== 32'h11223344) begin n_fail++; $display("FAIL t5_prior_value: got %h want 11223344", rd); end
  endtask

  task automatic test_input_hold();
    int lat, bb, tb; logic [31:0] rd; logic er;
    for (int s = 0; s < 2; s++) begin
      run_req(s, 1'b1, 2'd2, 32'h40, 32'h12345678, 1'b1, lat, rd, er, bb, tb);
      run_req(s, 1'b0, 2'd2, 32'h40, 32'h0, 1'b1, lat, rd, er, bb, tb);
      n_cmp++; if (rd !== 32'h12345678 || er !== 1'b0) begin n_fail++; $display("FAIL t6_hold[%0d]: got %h err %b want 12345678 0", s, rd, er); end
    end
  endtask

  task automatic test_random(input int s);
    int lat, bb, tb, exp_lat; logic [31:0] rd; logic er;
    logic w, sc, exp_e; logic [1:0] sz; logic [31:0] a, v, exp_rd;
    exp_lat = (s == 0) ? 1 : 3;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      run_req(s, 1'b1, 2'd2, BASE + 32'(4*i), v, 1'b0, lat, rd, er, bb, tb);
      model_store(s, 2'd2, BASE + 32'(4*i), v);
      n_cmp++; if (lat !== exp_lat || er !== 1'b0) begin n_fail++; $display("FAIL rnd_init[%0d]: lat %0d err %b want %0d 0", s, lat, er, exp_lat); end
    end
    for (int i = 0; i < 40; i++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sc = 1'($urandom_range(0, 1));
      v  = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'(4*DEPTH) + 32'($urandom_range(0, 255));
      else                           a = BASE + 32'($urandom_range(0, 63));
      exp_e  = model_err(sz, a);
      exp_rd = (!w && !exp_e) ? model_load(s, sz, a) : 32'h0;
      run_req(s, w, sz, a, v, sc, lat, rd, er, bb, tb);
      if (w && !exp_e) model_store(s, sz, a, v);
      n_cmp++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd_lat[%0d] #%0d: got %0d want %0d", s, i, lat, exp_lat); end
      n_cmp++; if (er !== exp_e) begin n_fail++; $display("FAIL rnd_err[%0d] #%0d a=%h sz=%0d: got %b want %b", s, i, a, sz, er, exp_e); end
      if (!w || exp_e) begin
        n_cmp++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata[%0d] #%0d a=%h sz=%0d: got %h want %h", s, i, a, sz, rd, exp_rd); end
      end
      n_cmp++; if (bb !== 0 || tb !== 0) begin n_fail++; $display("FAIL rnd_busy_tail[%0d] #%0d: busy_bad %0d tail_bad %0d want 0 0", s, i, bb, tb); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0; we[s] = 1'b0; size[s] = 2'd0; addr[s] = '0; wdata[s] = '0;
    end
    test_reset();
    test_word();
    test_lanes();
    test_errors();
    test_zero_latency();
    test_reset_mid_op();
    test_input_hold();
    test_random(0);
    test_random(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
